// File: rtl/cpu_stack_pkg.sv
// Shared definitions for the operand stack: default geometry, tagged-word layout
// and the writeback commit record.
package cpu_stack_pkg;

  localparam int DEF_DATA_W  = 35;
  localparam int DEF_DEPTH   = 2048;
  localparam int DEF_MAX_POP = 3;

  localparam int TAG_W = 3;
  localparam int VAL_W = 32;
  localparam int DEF_POP_W = $clog2(DEF_MAX_POP + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] value;
  } stack_word_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_POP_W-1:0] pop_cnt;
    logic                 push;
    stack_word_t          data;
  } stack_commit_t;

  function automatic logic [DEF_DATA_W-1:0] make_word(input logic [TAG_W-1:0] tag,
                                                      input logic [VAL_W-1:0] value);
    return {tag, value};
  endfunction

endpackage

// File: rtl/cpu_stack_if.sv
// Bundle between the pipeline (decode read side, execute restore, writeback
// commit) and the operand stack.
interface cpu_stack_if
  import cpu_stack_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_POP = DEF_MAX_POP
) ();
  localparam int SP_W  = $clog2(DEPTH) + 1;
  localparam int POP_W = $clog2(MAX_POP + 1);

  logic              commit_5a;
  logic [POP_W-1:0]  pop_cnt_5a;
  logic              push_5a;
  logic [DATA_W-1:0] push_data_5a;
  logic              restore_3a;
  logic [SP_W-1:0]   restore_sp_3a;
  logic [SP_W-1:0]   peek_idx_2a;
  logic [DATA_W-1:0] top_0_2a;
  logic [DATA_W-1:0] top_n_2a;
  logic              top_n_valid_2a;
  logic [SP_W-1:0]   sp_2a;
  logic              err_clr;
  logic              overflow;
  logic              underflow;

  modport master (
    output commit_5a, pop_cnt_5a, push_5a, push_data_5a,
    output restore_3a, restore_sp_3a, peek_idx_2a, err_clr,
    input  top_0_2a, top_n_2a, top_n_valid_2a, sp_2a, overflow, underflow
  );

  modport slave (
    input  commit_5a, pop_cnt_5a, push_5a, push_data_5a,
    input  restore_3a, restore_sp_3a, peek_idx_2a, err_clr,
    output top_0_2a, top_n_2a, top_n_valid_2a, sp_2a, overflow, underflow
  );

endinterface

// File: rtl/cpu_stack_ram.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
module cpu_stack_ram #(
  parameter int DATA_W = 35,
  parameter int DEPTH  = 2048,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/cpu_stack_file.sv
// Operand stack: pointer, registered top-of-stack, same-cycle push bypass toward
// decode and sticky overflow/underflow flags.
module cpu_stack_file
  import cpu_stack_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_POP = DEF_MAX_POP
) (
  input logic        clk,
  input logic        rst,
  cpu_stack_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int SP_W  = AW + 1;
  localparam int POP_W = $clog2(MAX_POP + 1);
  localparam logic [SP_W-1:0] DEPTH_SP  = SP_W'(DEPTH);
  localparam logic [SP_W:0]   DEPTH_EXT = (SP_W + 1)'(DEPTH);

  logic [SP_W-1:0]   sp_r;
  logic [DATA_W-1:0] top_r;
  logic              overflow_r;
  logic              underflow_r;

  logic [SP_W:0]     sp_ext_s, pop_ext_s, new_ext_s;
  logic [SP_W-1:0]   new_sp_s, rs_sp_s, base_s;
  logic              under_s, over_s, legal_s, bypass_s, wr_en_s, clamp_s, peek_ok_s;
  logic [AW-1:0]     wr_addr_s, rd_a_addr_s, rd_b_addr_s;
  logic [DATA_W-1:0] rd_a_data_s, rd_b_data_s, top_0_s, top_n_s;

  cpu_stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (wr_en_s),
    .waddr   (wr_addr_s),
    .wdata   (bus.push_data_5a),
    .raddr_a (rd_a_addr_s),
    .rdata_a (rd_a_data_s),
    .raddr_b (rd_b_addr_s),
    .rdata_b (rd_b_data_s)
  );

  // Commit legality, restore clamp and RAM port addressing.
  always_comb begin
    sp_ext_s  = {1'b0, sp_r};
    pop_ext_s = {{(SP_W + 1 - POP_W){1'b0}}, bus.pop_cnt_5a};
    new_ext_s = sp_ext_s - pop_ext_s + {{SP_W{1'b0}}, bus.push_5a};
    new_sp_s  = new_ext_s[SP_W-1:0];
    under_s   = bus.commit_5a && (pop_ext_s > sp_ext_s);
    over_s    = bus.commit_5a && !under_s && (new_ext_s > DEPTH_EXT);
    legal_s   = bus.commit_5a && !under_s && !over_s;
    bypass_s  = legal_s && bus.push_5a;
    wr_en_s   = bypass_s && !rst;
    wr_addr_s = AW'(new_sp_s - {{(SP_W - 1){1'b0}}, 1'b1});
    clamp_s   = bus.restore_sp_3a > DEPTH_SP;
    rs_sp_s   = clamp_s ? DEPTH_SP : bus.restore_sp_3a;
    // Port A refills the top register: restore target, else the new top after a pop.
    if (bus.restore_3a) begin
      rd_a_addr_s = AW'(rs_sp_s - {{(SP_W - 1){1'b0}}, 1'b1});
    end else begin
      rd_a_addr_s = wr_addr_s;
    end
    base_s      = bypass_s ? new_sp_s : sp_r;
    peek_ok_s   = bus.peek_idx_2a < base_s;
    rd_b_addr_s = AW'(base_s - {{(SP_W - 1){1'b0}}, 1'b1} - bus.peek_idx_2a);
  end

  // Decode-side read mux, including the same-cycle push bypass.
  always_comb begin
    if (bypass_s) begin
      top_0_s = bus.push_data_5a;
    end else if (sp_r == {SP_W{1'b0}}) begin
      top_0_s = {DATA_W{1'b0}};
    end else begin
      top_0_s = top_r;
    end
    if (!peek_ok_s) begin
      top_n_s = {DATA_W{1'b0}};
    end else if (bypass_s && (bus.peek_idx_2a == {SP_W{1'b0}})) begin
      top_n_s = bus.push_data_5a;
    end else begin
      top_n_s = rd_b_data_s;
    end
  end

  // Pointer, top register and sticky flag state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r        <= {SP_W{1'b0}};
      top_r       <= {DATA_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.restore_3a) begin
        sp_r <= rs_sp_s;
        if (bus.restore_sp_3a == {SP_W{1'b0}}) begin
          top_r <= {DATA_W{1'b0}};
        end else if (wr_en_s && (wr_addr_s == rd_a_addr_s)) begin
          top_r <= bus.push_data_5a;
        end else begin
          top_r <= rd_a_data_s;
        end
      end else if (legal_s) begin
        sp_r <= new_sp_s;
        if (bus.push_5a) begin
          top_r <= bus.push_data_5a;
        end else if (new_sp_s != {SP_W{1'b0}}) begin
          top_r <= rd_a_data_s;
        end else begin
          top_r <= top_r;
        end
      end else begin
        sp_r  <= sp_r;
        top_r <= top_r;
      end
      if (bus.err_clr) begin
        overflow_r  <= 1'b0;
        underflow_r <= 1'b0;
      end else begin
        overflow_r  <= overflow_r  | over_s | (bus.restore_3a & clamp_s);
        underflow_r <= underflow_r | under_s;
      end
    end
  end

  assign bus.top_0_2a       = top_0_s;
  assign bus.top_n_2a       = top_n_s;
  assign bus.top_n_valid_2a = peek_ok_s;
  assign bus.sp_2a          = sp_r;
  assign bus.overflow       = overflow_r;
  assign bus.underflow      = underflow_r;

endmodule

// File: doc/cpu_stack_file.md
Name: cpu_stack_file

Overview:
- Parametrised operand-stack storage for the stack-machine pipeline.
- Replaces the fixed 35-bit / 11-bit-pointer stack logic that is currently embedded in decode.
- Serves decode (2a) with top-of-stack and indexed peek reads.
- Accepts pop/push commits from writeback (5a) and stack-pointer restores from execute (3a).
- New over the current logic: configurable width, depth and pop count; same-cycle commit bypass; saturating overflow/underflow detection with sticky error flags.

Parameters:
- DATA_W, 35, width of one stack entry (tagged word).
- DEPTH, 2048, number of entries; power of two, at least 4.
- MAX_POP, 3, maximum entries popped by one commit.
- SP_W, clog2(DEPTH)+1, pointer width (derived; counts 0..DEPTH inclusive).
- POP_W, clog2(MAX_POP+1), width of the pop count (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- commit_5a  in  1  writeback commit valid
- pop_cnt_5a  in  POP_W  entries popped by the commit
- push_5a  in  1  commit pushes one entry (applied after the pop)
- push_data_5a  in  DATA_W  value pushed
- restore_3a  in  1  load SP from restore_sp_3a (kill/branch recovery)
- restore_sp_3a  in  SP_W  restored stack pointer
- peek_idx_2a  in  SP_W  depth below top for top_n (0 = top)
- top_0_2a  out  DATA_W  entry at SP-1
- top_n_2a  out  DATA_W  entry at SP-1-peek_idx_2a
- top_n_valid_2a  out  1  peek_idx_2a < SP
- sp_2a  out  SP_W  current stack pointer (entry count)
- err_clr  in  1  clears the sticky flags
- overflow  out  1  sticky: a commit would exceed DEPTH
- underflow  out  1  sticky: a commit popped more than SP

Behaviour:
- Reset: SP=0; overflow=0; underflow=0. top_0_2a=0, top_n_2a=0, top_n_valid_2a=0. RAM contents are not reset.
- Storage: DEPTH x DATA_W array. Single write port, combinational read ports (distributed RAM).
- Top register: top_0_2a comes from a registered copy of entry SP-1, not from the array read.
- Commit rules (commit_5a=1), with new = SP - pop_cnt_5a + push_5a:
  - pop_cnt_5a > SP: underflow<=1; SP, RAM and top register unchanged.
  - Otherwise, new > DEPTH: overflow<=1; SP, RAM and top register unchanged.
  - Otherwise: SP<=new. If push_5a, array[new-1]<=push_data_5a and the top register <=push_data_5a.
  - Otherwise, pop-only with new > 0: the top register <=array[new-1], read in the same cycle.
- Restore (restore_3a=1):
  - SP<=restore_sp_3a, clamped to DEPTH. A clamp also sets overflow.
  - Top register <=array[restore_sp_3a-1], or 0 if restore_sp_3a=0.
- Simultaneous restore and commit: the commit's RAM write still occurs because it is older. SP takes the restore value. If restore_sp_3a-1 equals the write address, the top register takes push_data_5a (bypass).
- Empty stack (SP=0): top_0_2a=0, top_n_2a=0, top_n_valid_2a=0.
- Reads are combinational from registered state, so a commit is visible to decode on the next cycle.
  - Exception, same-cycle bypass: if commit_5a && push_5a and the commit is legal, top_0_2a and top_n_2a return push_data_5a and new-based values in the commit cycle.
  - Reason: removes the 5a->2a stack hazard stall.
- peek_idx_2a >= SP: top_n_2a=0, top_n_valid_2a=0.
- Flags:
  - Sticky until err_clr. err_clr has priority over a same-cycle set.
  - A failed commit never corrupts state.
- Mid-operation reset: all state returns to reset values on the next edge. In-flight commits are dropped.
- Wrap-around: none. SP arithmetic is saturating and checked; addresses never wrap.

Decomposition:
- Shared package cpu_stack_pkg holds:
  - default DATA_W/DEPTH/MAX_POP
  - the tag-field layout of the 35-bit word (3-bit tag, 32-bit value)
  - a stack_commit_t struct {valid, pop_cnt, push, data}
- One sub-module, cpu_stack_ram: the parametrised DEPTH x DATA_W array with one synchronous write port and two asynchronous read ports.
- Pointer, top register, bypass and flag logic live in cpu_stack_file.

Test Plan:
- Reset, then push 0x1, 0x2, 0x3 (pop_cnt=0) -> SP=3, top_0=0x3; peek 2 -> 0x1 valid; peek 3 -> valid=0, data 0.
- From SP=3, commit pop_cnt=2, push=1, data 0x7 -> same-cycle top_0=0x7 (bypass); next cycle SP=2, top_0=0x7, peek 1 = 0x1.
- From SP=1, commit pop_cnt=3 -> underflow=1, SP stays 1, top_0 unchanged; err_clr -> underflow=0.
- Fill to SP=DEPTH, then push once -> overflow=1, SP=DEPTH, top unchanged; then pop_cnt=1 -> SP=DEPTH-1, top=entry DEPTH-2.
- At SP=5, restore_3a with restore_sp_3a=2 while committing push 0xAA at new=6 -> SP=2, top_0=entry 1; array[5]=0xAA, verified after restore_sp=6.
- Assert rst mid-sequence at SP=4 -> next cycle SP=0, flags 0, top_0=0, top_n_valid=0.
